fir_core_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 27 ++
 rtl/fir_seq_load_ctr.sv | 44 ++++
 rtl/fir_core_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fir_core_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_COEF = 3'd1,
        S_LOAD_SAMP = 3'd2,
        S_FLUSH     = 3'd3,
        S_START     = 3'd4,
        S_RUN       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [4:0] DEF_COEF_BASE   = 5'd10;
    localparam logic [4:0] DEF_SAMPLE_BASE = 5'd18;
    localparam int         CYCLE_W         = 16;
    // Wide enough to hold tap indices 0..7
    localparam int         TAP_CNT_W       = 4;

    // True when [a, a+n) and [b, b+n) share no register index
    function automatic bit ranges_disjoint(input int a, input int b, input int n);
        return (a + n <= b) || (b + n <= a);
    endfunction

endpackage

// File: rtl/fir_seq_load_ctr.sv
// Tap counter, coefficient/sample phase flag and register-file write address.
// Latency: address and end flags are combinational from the registered counter.
// Backpressure: advances only on an accepted load word (xfer).
module fir_seq_load_ctr
    import fir_seq_pkg::*;
#(
    parameter int         NUM_TAPS    = 4,
    parameter logic [4:0] COEF_BASE   = DEF_COEF_BASE,
    parameter logic [4:0] SAMPLE_BASE = DEF_SAMPLE_BASE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       xfer,
    output logic [4:0] waddr,
    output logic       coef_end,
    output logic       samp_end
);

    logic [TAP_CNT_W-1:0] tap_cnt;
    logic                 samp_phase;
    logic                 last_tap;

    assign last_tap = (tap_cnt == TAP_CNT_W'(NUM_TAPS - 1));
    assign coef_end = xfer & ~samp_phase & last_tap;
    assign samp_end = xfer &  samp_phase & last_tap;
    assign waddr    = (samp_phase ? SAMPLE_BASE : COEF_BASE) + 5'(tap_cnt);

    // Count accepted words; the wrap at the last coefficient switches to samples
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            tap_cnt    <= '0;
            samp_phase <= 1'b0;
        end else if (xfer) begin
            if (last_tap) begin
                tap_cnt    <= '0;
                samp_phase <= 1'b1;
            end else begin
                tap_cnt <= tap_cnt + TAP_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_core_sequencer.sv
// Loads FIR coefficients/samples into the core register file, launches the core, times the run.
// Latency: load word -> RF write 1 cycle; fir_start 2*NUM_TAPS+2 cycles after job_start with no stall.
// Backpressure: ld_ready high only in the load states; ld_valid gaps simply stretch the load phase.
// Optional feature macro: FIR_SEQ_TIMEOUT_EN (RUN aborts after TIMEOUT_CYCLES without a fir_done edge).
module fir_core_sequencer
    import fir_seq_pkg::*;
#(
    parameter int         NUM_TAPS       = 4,
    parameter logic [4:0] COEF_BASE      = DEF_COEF_BASE,
    parameter logic [4:0] SAMPLE_BASE    = DEF_SAMPLE_BASE,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_start,
    output logic        busy,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    output logic        fir_rf_we,
    output logic [4:0]  fir_rf_waddr,
    output logic [31:0] fir_rf_wdata,
    output logic        fir_start,
    input  logic        fir_done,
    output logic        job_done,
    output logic        job_timeout,
    output logic [15:0] cycle_count
);

    // Parameter sanity checks at elaboration
    if (NUM_TAPS < 1 || NUM_TAPS > 8) begin : g_bad_taps
        $error("NUM_TAPS must be in 1..8");
    end
    if (COEF_BASE == 5'd0 || SAMPLE_BASE == 5'd0) begin : g_bad_base
        $error("register index 0 cannot be a coefficient or sample base");
    end
    if (int'(SAMPLE_BASE) + NUM_TAPS > 32 || int'(COEF_BASE) + NUM_TAPS > 32) begin : g_bad_range
        $error("coefficient/sample range runs past register 31");
    end
    if (!ranges_disjoint(int'(COEF_BASE), int'(SAMPLE_BASE), NUM_TAPS)) begin : g_overlap
        $error("coefficient and sample ranges overlap");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the run counter");
    end

    state_t             state;
    logic [CYCLE_W-1:0] run_ctr;
    logic               done_prev;
    logic               fir_rise;
    logic               xfer;
    logic               ctr_clear;
    logic [4:0]         ctr_waddr;
    logic               coef_end;
    logic               samp_end;

    assign xfer      = ld_valid & ld_ready;
    assign ctr_clear = (state == S_IDLE) & job_start;
    assign fir_rise  = fir_done & ~done_prev;

    fir_seq_load_ctr #(
        .NUM_TAPS    (NUM_TAPS),
        .COEF_BASE   (COEF_BASE),
        .SAMPLE_BASE (SAMPLE_BASE)
    ) u_load_ctr (
        .clock    (clock),
        .reset    (reset),
        .clear    (ctr_clear),
        .xfer     (xfer),
        .waddr    (ctr_waddr),
        .coef_end (coef_end),
        .samp_end (samp_end)
    );

    // Previous-cycle fir_done sample, taken every cycle so a level left over
    // from an earlier job never looks like a fresh completion edge
    always_ff @(posedge clock) begin
        done_prev <= fir_done;
    end

`ifdef FIR_SEQ_TIMEOUT_EN
    logic job_timeout_r;
    assign job_timeout = job_timeout_r;
`else
    assign job_timeout = 1'b0;
`endif

    // Job FSM with registered handshake, RF write and status outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            ld_ready      <= 1'b0;
            fir_rf_we     <= 1'b0;
            fir_rf_waddr  <= 5'd0;
            fir_rf_wdata  <= 32'd0;
            fir_start     <= 1'b0;
            job_done      <= 1'b0;
            cycle_count   <= '0;
            run_ctr       <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            job_timeout_r <= 1'b0;
`endif
        end else begin
            fir_rf_we <= 1'b0;
            fir_start <= 1'b0;
            job_done  <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
            job_timeout_r <= 1'b0;
`endif
            // ld_ready is only high in the load states, so xfer implies one
            if (xfer) begin
                fir_rf_we    <= 1'b1;
                fir_rf_waddr <= ctr_waddr;
                fir_rf_wdata <= ld_data;
            end

            case (state)
                S_IDLE: begin
                    if (job_start) begin
                        state    <= S_LOAD_COEF;
                        busy     <= 1'b1;
                        ld_ready <= 1'b1;
                    end
                end
                S_LOAD_COEF: begin
                    if (coef_end) begin
                        state <= S_LOAD_SAMP;
                    end
                end
                S_LOAD_SAMP: begin
                    if (samp_end) begin
                        state    <= S_FLUSH;
                        ld_ready <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Last RF write is on the bus this cycle; launch next
                    state     <= S_START;
                    fir_start <= 1'b1;
                    run_ctr   <= '0;
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (fir_rise) begin
                        state       <= S_DONE;
                        job_done    <= 1'b1;
                        cycle_count <= run_ctr;
                    end
`ifdef FIR_SEQ_TIMEOUT_EN
                    else if (run_ctr == CYCLE_W'(TIMEOUT_CYCLES)) begin
                        state         <= S_DONE;
                        job_done      <= 1'b1;
                        job_timeout_r <= 1'b1;
                        cycle_count   <= run_ctr;
                    end
`endif
                    else if (run_ctr != {CYCLE_W{1'b1}}) begin
                        run_ctr <= run_ctr + CYCLE_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_core_sequencer.sv
`timescale 1ns/1ps
module tb_fir_core_sequencer;

    localparam int         NT = 4;
    localparam logic [4:0] CB = 5'd10;
    localparam logic [4:0] SB = 5'd18;
    localparam int         TO = 16;
`ifdef FIR_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        job_start;
    logic        busy;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        fir_rf_we;
    logic [4:0]  fir_rf_waddr;
    logic [31:0] fir_rf_wdata;
    logic        fir_start;
    logic        fir_done;
    logic        job_done;
    logic        job_timeout;
    logic [15:0] cycle_count;

    fir_core_sequencer #(
        .NUM_TAPS       (NT),
        .COEF_BASE      (CB),
        .SAMPLE_BASE    (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .job_start    (job_start),
        .busy         (busy),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .fir_rf_we    (fir_rf_we),
        .fir_rf_waddr (fir_rf_waddr),
        .fir_rf_wdata (fir_rf_wdata),
        .fir_start    (fir_start),
        .fir_done     (fir_done),
        .job_done     (job_done),
        .job_timeout  (job_timeout),
        .cycle_count  (cycle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Passive monitor, sampling 1ns after each rising edge
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t         wq[$];
    int          start_cnt = 0;
    int          start_cyc = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          stray_to  = 0;
    logic [15:0] done_val  = '0;
    logic        done_to   = 1'b0;

    always @(posedge clock) begin
        #1;
        if (fir_rf_we) wq.push_back('{a: fir_rf_waddr, d: fir_rf_wdata, c: cyc});
        if (fir_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (job_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_val = cycle_count;
            done_to  = job_timeout;
        end
        if (job_timeout && !job_done) stray_to++;
    end

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_busy"},  busy,         0);
        chk({pfx, "_ready"}, ld_ready,     0);
        chk({pfx, "_we"},    fir_rf_we,    0);
        chk({pfx, "_waddr"}, fir_rf_waddr, 0);
        chk({pfx, "_wdata"}, fir_rf_wdata, 0);
        chk({pfx, "_start"}, fir_start,    0);
        chk({pfx, "_done"},  job_done,     0);
        chk({pfx, "_tmo"},   job_timeout,  0);
        chk({pfx, "_count"}, cycle_count,  0);
    endtask

    // One full job. mode: 0 continuous valid, 1 alternate gaps, 2 random gaps.
    // k: fir_done rises k cycles after RUN entry. pre_high: fir_done already
    // high from before the job, dropped one cycle before the re-rise.
    // poke: pulse job_start while the core is running.
    task automatic run_job(input int mode, input bit seq_words, input int k,
                           input bit pre_high, input bit poke);
        logic [31:0] words [2*NT];
        int  idx = 0;
        int  b = 0;
        int  c0, last_acc, s0, d0, r0, exp_cnt, exp_dc;
        bit  exp_to, v;
        logic [4:0] ea;

        last_acc = 0;
        wq.delete();
        s0 = start_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 2*NT; i++) words[i] = seq_words ? 32'(i + 1) : $urandom;
        fir_done = pre_high;
        ld_valid = 1'b0;
        repeat (2) @(negedge clock);

        job_start = 1'b1;
        c0 = cyc;
        while (idx < 2*NT && b < 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (b % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_data  = v ? words[idx] : $urandom;
            if (v && ld_ready) begin
                idx++;
                last_acc = cyc;
            end
            @(negedge clock);
            job_start = 1'b0;
            b++;
        end
        ld_valid = 1'b0;
        chk("load_words", idx, 2*NT);

        b = 0;
        while (start_cnt == s0 && b < 20) begin
            @(negedge clock);
            b++;
        end
        chk("start_seen", start_cnt - s0, 1);
        chk("start_after_flush", start_cyc - last_acc, 2);
        if (mode == 0) chk("start_latency", start_cyc - c0, 2*NT + 2);

        r0 = start_cyc + 1;
        b = 0;
        while (done_cnt == d0 && b < 300) begin
            if (pre_high && cyc == r0 + k - 1) fir_done = 1'b0;
            if (cyc == r0 + k) fir_done = 1'b1;
            job_start = poke && (cyc == r0 + 1);
            ld_valid  = 1'($urandom_range(0, 1));
            ld_data   = $urandom;
            @(negedge clock);
            b++;
        end
        job_start = 1'b0;
        ld_valid  = 1'b0;

        if (TO_EN && k > TO) begin
            exp_cnt = TO;
            exp_to  = 1'b1;
        end else begin
            exp_cnt = k;
            exp_to  = 1'b0;
        end
        exp_dc = r0 + exp_cnt + 1;
        chk("done_seen", done_cnt - d0, 1);
        chk("done_cycle", done_cyc, exp_dc);
        chk("cycle_count", done_val, exp_cnt);
        chk("timeout_flag", done_to, exp_to);
        @(negedge clock);
        chk("busy_after_done", busy, 0);
        repeat (3) @(negedge clock);
        chk("done_once", done_cnt - d0, 1);
        chk("start_once", start_cnt - s0, 1);
        chk("count_hold", cycle_count, exp_cnt);

        chk("wr_count", wq.size(), 2*NT);
        for (int i = 0; i < wq.size() && i < 2*NT; i++) begin
            ea = (i < NT) ? CB + 5'(i) : SB + 5'(i - NT);
            chk("wr_addr", wq[i].a, ea);
            chk("wr_data", wq[i].d, words[i]);
            if (mode == 0) chk("wr_cycle", wq[i].c, c0 + 2 + i);
        end
        if (wq.size() > 0) chk("flush_last_write", wq[wq.size()-1].c, start_cyc - 1);
    endtask

    // Abort a job with reset after six words have been accepted
    task automatic reset_mid_job();
        int c0, d0;
        int b = 0;
        wq.delete();
        d0 = done_cnt;
        fir_done = 1'b0;
        repeat (2) @(negedge clock);
        job_start = 1'b1;
        ld_valid  = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 7 && b < 20) begin
            ld_data = 32'(100 + cyc - c0);
            @(negedge clock);
            job_start = 1'b0;
            b++;
        end
        reset = 1'b0;
        @(negedge clock);
        reset    = 1'b1;
        ld_valid = 1'b0;
        chk_idle_outputs("midrst");
        chk("midrst_wr_cnt", wq.size(), 6);
        if (wq.size() >= 6) begin
            chk("midrst_wr5_addr", wq[5].a, SB + 5'd1);
            chk("midrst_wr5_data", wq[5].d, 106);
        end
        repeat (10) @(negedge clock);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_more_wr", wq.size(), 6);
        chk("midrst_idle_busy", busy, 0);
    endtask

    initial begin
        reset     = 1'b0;
        job_start = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        fir_done  = 1'b0;
        repeat (3) @(negedge clock);
        chk_idle_outputs("rst");
        reset = 1'b1;

        run_job(0, 1'b1, 50, 1'b0, 1'b0);
        run_job(1, 1'b0, $urandom_range(5, 40), 1'b0, 1'b0);
        run_job(2, 1'b0, $urandom_range(3, 12), 1'b1, 1'b0);
        run_job(0, 1'b0, 20, 1'b0, 1'b1);
        run_job(0, 1'b0, 0, 1'b0, 1'b0);
        run_job(0, 1'b0, 100, 1'b0, 1'b0);
        reset_mid_job();
        run_job(0, 1'b1, 30, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            run_job($urandom_range(0, 2), 1'b0, $urandom_range(3, 40),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("stray_timeout", stray_to, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
